// File: rtl/mult_pipe_pkg.sv
// rtl/mult_pipe_pkg.sv - shared widths, depth and per-stage record for the pipelined multiplier
package mult_pipe_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int MULT_STAGES = 5;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] acc;
  } mult_stage_t;

  // A stage only claims a register-file write when it holds a live op aimed at rd != 0.
  function automatic logic stage_wr_en(input mult_stage_t s);
    return s.valid && (s.rd != '0);
  endfunction

endpackage

// File: rtl/mult_stage.sv
// rtl/mult_stage.sv - one multiplier pipeline stage: adds one shifted byte partial product, or passes through
module mult_stage
  import mult_pipe_pkg::*;
#(
  parameter int BYTE_IDX = 0,
  parameter bit PASS     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  mult_stage_t stage_i,
  output mult_stage_t stage_o
);

  logic [7:0]        b_byte;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] acc_next;

  assign b_byte = stage_i.b[8*BYTE_IDX +: 8];

  always_comb begin
    partial  = stage_i.a * {{(DATA_W-8){1'b0}}, b_byte};
    acc_next = PASS ? stage_i.acc : stage_i.acc + (partial << (8*BYTE_IDX));
  end

  // Flush only kills the valid bit; stale data/rd are harmless once valid is low.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      stage_o <= '0;
    end else if (flush_i) begin
      stage_o.valid <= 1'b0;
    end else if (!stall_i) begin
      stage_o     <= stage_i;
      stage_o.acc <= acc_next;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - 5-stage 32x32->32 low-word multiplier with per-stage bypass taps
module mult_pipe
  import mult_pipe_pkg::*;
(
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] mult1_data_o,
  output logic [ADDR_W-1:0] mult1_addr_o,
  output logic              mult1_wr_en_o,
  output logic [DATA_W-1:0] mult2_data_o,
  output logic [ADDR_W-1:0] mult2_addr_o,
  output logic              mult2_wr_en_o,
  output logic [DATA_W-1:0] mult3_data_o,
  output logic [ADDR_W-1:0] mult3_addr_o,
  output logic              mult3_wr_en_o,
  output logic [DATA_W-1:0] mult4_data_o,
  output logic [ADDR_W-1:0] mult4_addr_o,
  output logic              mult4_wr_en_o,
  output logic [DATA_W-1:0] mult5_data_o,
  output logic [ADDR_W-1:0] mult5_addr_o,
  output logic              mult5_wr_en_o,
  output logic              result_valid_o,
  output logic              busy_o
);

  // st[0] is the issue slot; st[k] is the register of stage k.
  mult_stage_t            st [0:MULT_STAGES];
  logic [MULT_STAGES-1:0] wr_en;

  assign ready_o = !stall_i;

  always_comb begin
    st[0]       = '0;
    st[0].valid = valid_i;
    st[0].rd    = rd_i;
    st[0].a     = op_a_i;
    st[0].b     = op_b_i;
  end

  // Stages 1..4 each fold in one byte of b; stage 5 only retimes the result.
  for (genvar k = 0; k < MULT_STAGES; k++) begin : g_stage
    mult_stage #(
      .BYTE_IDX ((k < 4) ? k : 0),
      .PASS     (k == MULT_STAGES - 1)
    ) u_stage (
      .clk_i   (clk_i),
      .rsn_i   (rsn_i),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .stage_i (st[k]),
      .stage_o (st[k+1])
    );
    assign wr_en[k] = stage_wr_en(st[k+1]);
  end

  assign mult1_data_o  = st[1].acc;
  assign mult1_addr_o  = st[1].rd;
  assign mult1_wr_en_o = wr_en[0];
  assign mult2_data_o  = st[2].acc;
  assign mult2_addr_o  = st[2].rd;
  assign mult2_wr_en_o = wr_en[1];
  assign mult3_data_o  = st[3].acc;
  assign mult3_addr_o  = st[3].rd;
  assign mult3_wr_en_o = wr_en[2];
  assign mult4_data_o  = st[4].acc;
  assign mult4_addr_o  = st[4].rd;
  assign mult4_wr_en_o = wr_en[3];
  assign mult5_data_o  = st[5].acc;
  assign mult5_addr_o  = st[5].rd;
  assign mult5_wr_en_o = wr_en[4];

  assign result_valid_o = wr_en[4];
  assign busy_o         = |wr_en;

endmodule

// File: tb/tb_mult_pipe.sv
// tb/tb_mult_pipe.sv - directed table-driven and sequence checks for mult_pipe
module tb_mult_pipe;

  logic        clk = 1'b0;
  logic        rsn_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic [4:0]  rd_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ready_o;
  logic [31:0] mult1_data_o, mult2_data_o, mult3_data_o, mult4_data_o, mult5_data_o;
  logic [4:0]  mult1_addr_o, mult2_addr_o, mult3_addr_o, mult4_addr_o, mult5_addr_o;
  logic        mult1_wr_en_o, mult2_wr_en_o, mult3_wr_en_o, mult4_wr_en_o, mult5_wr_en_o;
  logic        result_valid_o, busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_pipe dut (
    .clk_i(clk), .rsn_i(rsn_i), .valid_i(valid_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .rd_i(rd_i), .stall_i(stall_i), .flush_i(flush_i), .ready_o(ready_o),
    .mult1_data_o(mult1_data_o), .mult1_addr_o(mult1_addr_o), .mult1_wr_en_o(mult1_wr_en_o),
    .mult2_data_o(mult2_data_o), .mult2_addr_o(mult2_addr_o), .mult2_wr_en_o(mult2_wr_en_o),
    .mult3_data_o(mult3_data_o), .mult3_addr_o(mult3_addr_o), .mult3_wr_en_o(mult3_wr_en_o),
    .mult4_data_o(mult4_data_o), .mult4_addr_o(mult4_addr_o), .mult4_wr_en_o(mult4_wr_en_o),
    .mult5_data_o(mult5_data_o), .mult5_addr_o(mult5_addr_o), .mult5_wr_en_o(mult5_wr_en_o),
    .result_valid_o(result_valid_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    valid_i = 1'b1; op_a_i = a; op_b_i = b; rd_i = rd;
  endtask

  task automatic idle();
    valid_i = 1'b0; op_a_i = '0; op_b_i = '0; rd_i = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, {mult1_data_o | mult2_data_o | mult3_data_o | mult4_data_o | mult5_data_o}, 32'h0);
    chk({tag, "_addr"}, {27'h0, mult1_addr_o | mult2_addr_o | mult3_addr_o | mult4_addr_o | mult5_addr_o}, 32'h0);
    chk({tag, "_wr_en"}, {27'h0, mult1_wr_en_o, mult2_wr_en_o, mult3_wr_en_o, mult4_wr_en_o, mult5_wr_en_o}, 32'h0);
    chk({tag, "_result_valid"}, {31'h0, result_valid_o}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 5'd7,  32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0001};
    vecs[2] = '{32'h0001_0000, 32'h0001_0000, 5'd2,  32'h0000_0000};
    vecs[3] = '{32'h0000_FFFF, 32'h0000_FFFF, 5'd3,  32'hFFFE_0001};
    vecs[4] = '{32'h0102_0304, 32'h0000_0100, 5'd4,  32'h0203_0400};
    vecs[5] = '{32'h0000_0007, 32'h0100_0000, 5'd31, 32'h0700_0000};
    vecs[6] = '{32'h0000_0010, 32'h0001_0000, 5'd16, 32'h0010_0000};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0003, 5'd9,  32'hFFFF_FFFD};

    // Reset
    step(); step();
    rsn_i = 1'b0;
    chk_all_zero("reset");
    chk("reset_ready", {31'h0, ready_o}, 32'h1);

    // Table: one op at a time, result visible four edges after the acceptance edge
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].rd);
      step();
      idle();
      chk($sformatf("vec%0d_s1_wr_en", i), {31'h0, mult1_wr_en_o}, 32'h1);
      for (int s = 0; s < 3; s++) begin
        step();
        chk($sformatf("vec%0d_early_valid%0d", i, s), {31'h0, result_valid_o}, 32'h0);
      end
      step();
      chk($sformatf("vec%0d_data", i), mult5_data_o, vecs[i].exp);
      chk($sformatf("vec%0d_addr", i), {27'h0, mult5_addr_o}, {27'h0, vecs[i].rd});
      chk($sformatf("vec%0d_valid", i), {31'h0, result_valid_o}, 32'h1);
      step();
      chk($sformatf("vec%0d_valid_drop", i), {31'h0, result_valid_o}, 32'h0);
      chk($sformatf("vec%0d_busy_drop", i), {31'h0, busy_o}, 32'h0);
    end

    // Back-to-back: rd=1..5, a=rd, b=10
    for (int i = 1; i <= 5; i++) begin
      issue(i, 32'd10, i[4:0]);
      step();
    end
    idle();
    chk("b2b_addr1", {27'h0, mult1_addr_o}, 32'd5);
    chk("b2b_addr2", {27'h0, mult2_addr_o}, 32'd4);
    chk("b2b_addr3", {27'h0, mult3_addr_o}, 32'd3);
    chk("b2b_addr4", {27'h0, mult4_addr_o}, 32'd2);
    chk("b2b_addr5", {27'h0, mult5_addr_o}, 32'd1);
    chk("b2b_wr_en", {27'h0, mult1_wr_en_o, mult2_wr_en_o, mult3_wr_en_o, mult4_wr_en_o, mult5_wr_en_o}, 32'h1F);
    chk("b2b_busy", {31'h0, busy_o}, 32'h1);
    chk("b2b_data1", mult5_data_o, 32'd10);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk($sformatf("b2b_out%0d_addr", i), {27'h0, mult5_addr_o}, i);
      chk($sformatf("b2b_out%0d_data", i), mult5_data_o, i * 10);
      chk($sformatf("b2b_out%0d_valid", i), {31'h0, result_valid_o}, 32'h1);
    end
    step();
    chk("b2b_drain", {31'h0, result_valid_o}, 32'h0);

    // Stall with op in S2; issue attempted during stall must be ignored
    issue(32'd6, 32'd7, 5'd9);
    step();
    idle();
    step();
    chk("stall_pre_s2", {27'h0, mult2_addr_o}, 32'd9);
    stall_i = 1'b1;
    issue(32'd100, 32'd100, 5'd3);
    #1;
    chk("stall_ready", {31'h0, ready_o}, 32'h0);
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("stall%0d_s2_addr", s), {27'h0, mult2_addr_o}, 32'd9);
      chk($sformatf("stall%0d_s2_wr_en", s), {31'h0, mult2_wr_en_o}, 32'h1);
      chk($sformatf("stall%0d_s1_wr_en", s), {31'h0, mult1_wr_en_o}, 32'h0);
      chk($sformatf("stall%0d_s3_wr_en", s), {31'h0, mult3_wr_en_o}, 32'h0);
    end
    stall_i = 1'b0;
    idle();
    step(); step();
    chk("stall_s4_not_yet", {31'h0, result_valid_o}, 32'h0);
    step();
    chk("stall_late_valid", {31'h0, result_valid_o}, 32'h1);
    chk("stall_late_data", mult5_data_o, 32'd42);
    chk("stall_late_addr", {27'h0, mult5_addr_o}, 32'd9);
    step();
    chk("stall_drained_busy", {31'h0, busy_o}, 32'h0);

    // Flush beats stall and valid: fill S1..S4, then flush
    for (int i = 1; i <= 4; i++) begin
      issue(i, 32'd3, i[4:0]);
      step();
    end
    chk("flush_pre_busy", {27'h0, mult1_wr_en_o, mult2_wr_en_o, mult3_wr_en_o, mult4_wr_en_o, mult5_wr_en_o}, 32'h1E);
    issue(32'd5, 32'd5, 5'd6);
    flush_i = 1'b1;
    stall_i = 1'b1;
    step();
    flush_i = 1'b0;
    stall_i = 1'b0;
    idle();
    chk("flush_wr_en", {27'h0, mult1_wr_en_o, mult2_wr_en_o, mult3_wr_en_o, mult4_wr_en_o, mult5_wr_en_o}, 32'h0);
    chk("flush_busy", {31'h0, busy_o}, 32'h0);
    for (int s = 0; s < 6; s++) begin
      step();
      chk($sformatf("flush_no_result%0d", s), {31'h0, result_valid_o}, 32'h0);
    end

    // rd=0: data flows, no write enables
    issue(32'd2, 32'd2, 5'd0);
    step();
    idle();
    chk("rd0_busy_s1", {31'h0, busy_o}, 32'h0);
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("rd0_busy%0d", s), {31'h0, busy_o}, 32'h0);
    end
    chk("rd0_data", mult5_data_o, 32'd4);
    chk("rd0_valid", {31'h0, result_valid_o}, 32'h0);

    // Reset with S3 live
    issue(32'd11, 32'd13, 5'd8);
    step();
    idle();
    step(); step();
    chk("rst_s3_live", {31'h0, mult3_wr_en_o}, 32'h1);
    rsn_i = 1'b1;
    step();
    rsn_i = 1'b0;
    chk_all_zero("midreset");
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("midreset_no_result%0d", s), {31'h0, result_valid_o}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
